mem_access_initiator: RTL and testbench

- CPU-side initiator for the byte-wide memory controller. Accepts one load or store command at a time from the core (sizes 1, 2, 4 or 5 bytes) and drives the controller's read4, read5, write1, write4 and write5 request ports.
- Issues each request as a single-cycle strobe, waits for the matching Complete pulse, then returns a right-aligned, zero-extended 40-bit result with an error flag.
- Sits between the execute/fetch logic and the memory controller. It is the only driver of those controller ports.

---
 rtl/mem_access_initiator_pkg.sv | 43 ++++
 rtl/mem_rsp_align.sv | 29 ++
 rtl/mem_access_initiator.sv | 203 ++++++++++++++++++++
 tb/tb_mem_access_initiator.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_initiator_pkg.sv
// Shared encodings for the memory access initiator: request sizes, FSM
// states, controller port selection and the {write,size} -> port mapping.
package mem_access_initiator_pkg;

   localparam logic [1:0] SIZE_1B = 2'd0;
   localparam logic [1:0] SIZE_2B = 2'd1;
   localparam logic [1:0] SIZE_4B = 2'd2;
   localparam logic [1:0] SIZE_5B = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_t;

   typedef enum logic [2:0] {
      PORT_R4,
      PORT_R5,
      PORT_W1,
      PORT_W4,
      PORT_W5,
      PORT_NONE
   } port_t;

   // Loads of up to 4 bytes share read4 and are narrowed afterwards; there is
   // no 2-byte write port, so a 2-byte store has nowhere to go.
   function automatic port_t port_of(input logic write, input logic [1:0] size);
      port_t p;
      if (!write) begin
         p = (size == SIZE_5B) ? PORT_R5 : PORT_R4;
      end else begin
         case (size)
            SIZE_1B: p = PORT_W1;
            SIZE_4B: p = PORT_W4;
            SIZE_5B: p = PORT_W5;
            default: p = PORT_NONE;
         endcase
      end
      return p;
   endfunction

endpackage

// File: rtl/mem_rsp_align.sv
// Right-aligns and zero-extends read data. Memory is big-endian, so narrow
// loads take the most-significant bytes of the read4 buffer.
module mem_rsp_align
   import mem_access_initiator_pkg::*;
(
   input  port_t       port,
   input  logic [1:0]  size,
   input  logic [31:0] rd4_buf,
   input  logic [39:0] rd5_buf,
   output logic [39:0] rdata
);

   // Select and align; stores and unsupported ops return zero
   always_comb begin
      rdata = '0;
      case (port)
         PORT_R4: begin
            case (size)
               SIZE_1B: rdata = {32'b0, rd4_buf[31:24]};
               SIZE_2B: rdata = {24'b0, rd4_buf[31:16]};
               default: rdata = {8'b0, rd4_buf};
            endcase
         end
         PORT_R5: rdata = rd5_buf;
         default: rdata = '0;
      endcase
   end

endmodule

// File: rtl/mem_access_initiator.sv
// CPU-side initiator for the byte-wide memory controller: accepts one
// load/store, issues a single-cycle strobe, waits for the armed Complete
// (or a timeout) and returns a registered one-cycle response.
module mem_access_initiator
   import mem_access_initiator_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [39:0]           req_wdata,
   output logic                  rsp_valid,
   output logic [39:0]           rsp_rdata,
   output logic                  rsp_err,
   output logic                  mc_read4,
   output logic                  mc_read5,
   output logic                  mc_write1,
   output logic                  mc_write4,
   output logic                  mc_write5,
   output logic [ADDR_WIDTH-1:0] mc_read4_address,
   output logic [ADDR_WIDTH-1:0] mc_read5_address,
   output logic [ADDR_WIDTH-1:0] mc_write1_address,
   output logic [ADDR_WIDTH-1:0] mc_write4_address,
   output logic [ADDR_WIDTH-1:0] mc_write5_address,
   output logic [7:0]            mc_write1_buffer,
   output logic [31:0]           mc_write4_buffer,
   output logic [39:0]           mc_write5_buffer,
   input  logic [31:0]           mc_read4_buffer,
   input  logic [39:0]           mc_read5_buffer,
   input  logic                  mc_read4_active,
   input  logic                  mc_read5_active,
   input  logic                  mc_write1_active,
   input  logic                  mc_write4_active,
   input  logic                  mc_write5_active,
   input  logic                  mc_read4_complete,
   input  logic                  mc_read5_complete,
   input  logic                  mc_write1_complete,
   input  logic                  mc_write4_complete,
   input  logic                  mc_write5_complete
);

   localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t                  state, state_nxt;
   port_t                   port_q;
   logic [1:0]              size_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [39:0]             wdata_q;
   logic                    armed;
   logic [CNT_W-1:0]        cnt;
   logic [39:0]             rdata_q;
   logic                    err_q;
   logic [39:0]             aligned;
   port_t                   req_port;
   logic                    sel_active, sel_complete;
   logic                    capture, done_ok, timed_out;

   assign req_port  = port_of(req_write, req_size);
   assign req_ready = (state == ST_IDLE);

   // Strobes decode from registered state only, so reset drops them at once
   assign mc_read4  = (state == ST_ISSUE) && (port_q == PORT_R4);
   assign mc_read5  = (state == ST_ISSUE) && (port_q == PORT_R5);
   assign mc_write1 = (state == ST_ISSUE) && (port_q == PORT_W1);
   assign mc_write4 = (state == ST_ISSUE) && (port_q == PORT_W4);
   assign mc_write5 = (state == ST_ISSUE) && (port_q == PORT_W5);

   // Address/data come straight from the holding registers and stay put
   // until the next command is captured.
   assign mc_read4_address  = addr_q;
   assign mc_read5_address  = addr_q;
   assign mc_write1_address = addr_q;
   assign mc_write4_address = addr_q;
   assign mc_write5_address = addr_q;
   assign mc_write1_buffer  = wdata_q[7:0];
   assign mc_write4_buffer  = wdata_q[31:0];
   assign mc_write5_buffer  = wdata_q;

   // Handshake inputs of the port the held command targets
   always_comb begin
      sel_active   = 1'b0;
      sel_complete = 1'b0;
      case (port_q)
         PORT_R4: begin sel_active = mc_read4_active;  sel_complete = mc_read4_complete;  end
         PORT_R5: begin sel_active = mc_read5_active;  sel_complete = mc_read5_complete;  end
         PORT_W1: begin sel_active = mc_write1_active; sel_complete = mc_write1_complete; end
         PORT_W4: begin sel_active = mc_write4_active; sel_complete = mc_write4_complete; end
         PORT_W5: begin sel_active = mc_write5_active; sel_complete = mc_write5_complete; end
         default: ;
      endcase
   end

   mem_rsp_align u_align (
      .port    (port_q),
      .size    (size_q),
      .rd4_buf (mc_read4_buffer),
      .rd5_buf (mc_read5_buffer),
      .rdata   (aligned)
   );

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next-state decode and per-cycle control events
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      done_ok   = 1'b0;
      timed_out = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req_valid) begin
               capture   = 1'b1;
               state_nxt = (req_port == PORT_NONE) ? ST_RESP : ST_ISSUE;
            end
         end
         ST_ISSUE: state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (sel_complete && armed) begin
               done_ok   = 1'b1;
               state_nxt = ST_RESP;
            end else if (cnt == CNT_LAST) begin
               timed_out = 1'b1;
               state_nxt = ST_RESP;
            end
         end
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Holding registers for the accepted command
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         port_q  <= PORT_NONE;
         size_q  <= SIZE_1B;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (capture) begin
         port_q  <= req_port;
         size_q  <= req_size;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
      end
   end

   // Wait-phase bookkeeping: arm on Active, count toward the timeout
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         armed <= 1'b0;
         cnt   <= '0;
      end else if (state == ST_WAIT) begin
         cnt <= cnt + 1'b1;
         if (sel_active) armed <= 1'b1;
      end else if (state == ST_RESP) begin
         armed <= 1'b0;
         cnt   <= '0;
      end
   end

   // Pending result: unsupported errors at capture, data or timeout in WAIT
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (capture) begin
         rdata_q <= '0;
         err_q   <= (req_port == PORT_NONE);
      end else if (done_ok) begin
         rdata_q <= aligned;
         err_q   <= 1'b0;
      end else if (timed_out) begin
         rdata_q <= '0;
         err_q   <= 1'b1;
      end
   end

   // Registered response pulse, launched from RESP
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= (state == ST_RESP);
         if (state == ST_RESP) begin
            rsp_rdata <= rdata_q;
            rsp_err   <= err_q;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_initiator.sv
// Directed bench for mem_access_initiator: a byte-memory controller stub,
// a response scoreboard and a linear sequence of load/store steps.
module tb_mem_access_initiator;
   import mem_access_initiator_pkg::*;

   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_write = 1'b0;
   logic [1:0]    req_size = 2'd0;
   logic [AW-1:0] req_addr = '0;
   logic [39:0]   req_wdata = '0;
   logic          rsp_valid;
   logic [39:0]   rsp_rdata;
   logic          rsp_err;
   logic          mc_read4, mc_read5, mc_write1, mc_write4, mc_write5;
   logic [AW-1:0] mc_read4_address, mc_read5_address, mc_write1_address;
   logic [AW-1:0] mc_write4_address, mc_write5_address;
   logic [7:0]    mc_write1_buffer;
   logic [31:0]   mc_write4_buffer;
   logic [39:0]   mc_write5_buffer;
   logic [31:0]   r4buf = '0;
   logic [39:0]   r5buf = '0;
   logic [4:0]    act = '0;
   logic [4:0]    cmp = '0;
   logic          inj_c5 = 1'b0;
   logic          hang = 1'b0;

   typedef struct packed {
      logic [39:0] rdata;
      logic        err;
   } exp_t;
   exp_t sb[$];

   logic [7:0] mem [256];
   int vectors = 0;
   int errs = 0;
   int cyc = 0;
   int rsp_seen = 0;
   int last_rsp_cyc = 0;
   int strobe_cyc = 0;
   int cmpl_cyc = 0;
   int drive_cyc = 0;
   int nstrobes = 0;
   int strobe_cnt [5];
   int sport = 0;
   int scnt = 0;
   int sa = 0;
   logic busy = 1'b0;

   mem_access_initiator #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mc_read4(mc_read4), .mc_read5(mc_read5), .mc_write1(mc_write1),
      .mc_write4(mc_write4), .mc_write5(mc_write5),
      .mc_read4_address(mc_read4_address), .mc_read5_address(mc_read5_address),
      .mc_write1_address(mc_write1_address), .mc_write4_address(mc_write4_address),
      .mc_write5_address(mc_write5_address),
      .mc_write1_buffer(mc_write1_buffer), .mc_write4_buffer(mc_write4_buffer),
      .mc_write5_buffer(mc_write5_buffer),
      .mc_read4_buffer(r4buf), .mc_read5_buffer(r5buf),
      .mc_read4_active(act[0]), .mc_read5_active(act[1]), .mc_write1_active(act[2]),
      .mc_write4_active(act[3]), .mc_write5_active(act[4]),
      .mc_read4_complete(cmp[0]), .mc_read5_complete(cmp[1] | inj_c5),
      .mc_write1_complete(cmp[2]), .mc_write4_complete(cmp[3]),
      .mc_write5_complete(cmp[4])
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // Controller stub: Active one cycle after the strobe, Complete two later
   always @(negedge clk) begin
      logic [4:0] strb;
      if (reset) begin
         busy = 1'b0;
         act  = '0;
         cmp  = '0;
      end else begin
         cmp  = '0;
         strb = {mc_write5, mc_write4, mc_write1, mc_read5, mc_read4};
         if (strb != 5'b0) begin
            act = '0;
            for (int i = 0; i < 5; i++)
               if (strb[i]) begin sport = i; strobe_cnt[i]++; end
            nstrobes++;
            busy = 1'b1;
            scnt = 0;
            strobe_cyc = cyc;
            sa = int'(mc_read4_address[7:0]);
         end else if (busy) begin
            scnt++;
            if (scnt == 1) act[sport] = 1'b1;
            if (scnt == 3 && !hang) begin
               act[sport] = 1'b0;
               cmp[sport] = 1'b1;
               cmpl_cyc   = cyc;
               busy       = 1'b0;
               case (sport)
                  0: r4buf = {mem[sa], mem[sa+1], mem[sa+2], mem[sa+3]};
                  1: r5buf = {mem[sa], mem[sa+1], mem[sa+2], mem[sa+3], mem[sa+4]};
                  2: mem[sa] = mc_write1_buffer;
                  3: {mem[sa], mem[sa+1], mem[sa+2], mem[sa+3]} = mc_write4_buffer;
                  default: {mem[sa], mem[sa+1], mem[sa+2], mem[sa+3], mem[sa+4]} = mc_write5_buffer;
               endcase
            end
         end
      end
   end

   // Scoreboard: compare every response against the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (!reset && rsp_valid) begin
         rsp_seen++;
         last_rsp_cyc = cyc;
         if (sb.size() == 0) begin
            check("sb_unexpected_rsp", 64'(sb.size()), 64'd1);
         end else begin
            e = sb.pop_front();
            check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            check("rsp_err", 64'(rsp_err), 64'(e.err));
         end
      end
   end

   task automatic do_cmd(input logic w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [39:0] wd, input logic [39:0] er, input logic ee);
      int n;
      sb.push_back('{rdata: er, err: ee});
      n = 0;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      req_valid = 1'b1; req_write = w; req_size = sz; req_addr = a; req_wdata = wd;
      drive_cyc = cyc;
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
      check("rsp_arrived", 64'(sb.size()), 64'd0);
      sb.delete();
   endtask

   initial begin
      int tot, seen;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      for (int i = 0; i < 5; i++) strobe_cnt[i] = 0;
      mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33;
      mem[8'h13] = 8'h44; mem[8'h14] = 8'h55;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_req_ready", 64'(req_ready), 64'd1);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_strobes", 64'({mc_read4, mc_read5, mc_write1, mc_write4, mc_write5}), 64'd0);
      check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // 1: load 4B, single-cycle strobe, 2-cycle latency from Complete
      do_cmd(1'b0, SIZE_4B, 32'h10, 40'h0, 40'h0011223344, 1'b0);
      check("t1_latency", 64'(last_rsp_cyc - cmpl_cyc), 64'd2);
      check("t1_read4_cycles", 64'(strobe_cnt[0]), 64'd1);

      // 2: narrow loads and 5B through read5
      do_cmd(1'b0, SIZE_1B, 32'h10, 40'h0, 40'h11, 1'b0);
      do_cmd(1'b0, SIZE_2B, 32'h10, 40'h0, 40'h1122, 1'b0);
      do_cmd(1'b0, SIZE_5B, 32'h10, 40'h0, 40'h1122334455, 1'b0);
      check("t2_read5_cycles", 64'(strobe_cnt[1]), 64'd1);

      // 3: stores then read-back
      do_cmd(1'b1, SIZE_4B, 32'h20, 40'hFF_DEADBEEF, 40'h0, 1'b0);
      do_cmd(1'b0, SIZE_4B, 32'h20, 40'h0, 40'h00DEADBEEF, 1'b0);
      do_cmd(1'b1, SIZE_1B, 32'h21, 40'h12345678A5, 40'h0, 1'b0);
      do_cmd(1'b0, SIZE_4B, 32'h20, 40'h0, 40'h00DEA5BEEF, 1'b0);
      check("t3_write4_cycles", 64'(strobe_cnt[3]), 64'd1);

      // 4: unsupported 2B store
      tot = nstrobes;
      do_cmd(1'b1, SIZE_2B, 32'h30, 40'h0000001234, 40'h0, 1'b1);
      check("t4_latency", 64'(last_rsp_cyc - drive_cyc), 64'd2);
      check("t4_no_strobe", 64'(nstrobes), 64'(tot));

      // 5: controller never completes -> timeout after 16 WAIT cycles
      hang = 1'b1;
      do_cmd(1'b0, SIZE_4B, 32'h10, 40'h0, 40'h0, 1'b1);
      check("t5_timeout_cycles", 64'(last_rsp_cyc - strobe_cyc), 64'd18);
      hang = 1'b0;
      do_cmd(1'b0, SIZE_1B, 32'h10, 40'h0, 40'h11, 1'b0);

      // 6: stale Complete before arming, then reset during WAIT
      hang = 1'b1;
      seen = rsp_seen;
      req_valid = 1'b1; req_write = 1'b0; req_size = SIZE_5B; req_addr = 32'h10;
      @(negedge clk);
      req_valid = 1'b0;
      inj_c5 = 1'b1;
      check("t6_issue_strobe", 64'(mc_read5), 64'd1);
      @(negedge clk);
      @(negedge clk);
      inj_c5 = 1'b0;
      repeat (3) @(negedge clk);
      check("t6_stale_ignored", 64'(rsp_seen), 64'(seen));
      check("t6_busy_in_wait", 64'(req_ready), 64'd0);
      #2 reset = 1'b1;
      #1;
      check("t6_rst_strobes", 64'({mc_read4, mc_read5, mc_write1, mc_write4, mc_write5}), 64'd0);
      check("t6_rst_ready", 64'(req_ready), 64'd1);
      check("t6_rst_addr", 64'(mc_read5_address), 64'd0);
      @(negedge clk);
      #2 reset = 1'b0;
      hang = 1'b0;
      repeat (10) @(negedge clk);
      check("t6_no_rsp", 64'(rsp_seen), 64'(seen));
      do_cmd(1'b0, SIZE_2B, 32'h10, 40'h0, 40'h1122, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

   // Absolute bound on the run in case a step stalls unexpectedly
   initial begin
      #200000;
      $display("FAIL global_timeout observed=%0d expected=finish", cyc);
      $fatal(1, "run did not finish");
   end

endmodule
